// File: rtl/lsu_pkg.sv
// ---------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the data-memory request controller:
//   - funct3 width/sign codes for loads and stores
//   - controller state enum
//   - base byte-lane mask patterns for stores
//   - helpers that classify an access and build a store lane mask
// ---------------------------------------------------------------------------
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  // Unshifted byte-lane enables; the store address offset shifts these.
  localparam logic [7:0] WMASK_B = 8'h01;
  localparam logic [7:0] WMASK_H = 8'h03;
  localparam logic [7:0] WMASK_W = 8'h0F;

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    WR,
    DONE
  } lsu_state_e;

  // An access is rejected when it is not exactly one of load/store, when
  // funct3 is not a legal code for its direction (stores have no unsigned
  // forms), or when a half/word is not naturally aligned.
  function automatic logic access_err(input logic       ld,
                                      input logic       st,
                                      input logic [2:0] f3,
                                      input logic [1:0] lo);
    logic err;
    err = (ld == st);
    case (f3)
      F3_B:    err = err;
      F3_H:    if (lo[0]) err = 1'b1;
      F3_W:    if (lo != 2'b00) err = 1'b1;
      F3_BU:   if (st) err = 1'b1;
      F3_HU:   if (st || lo[0]) err = 1'b1;
      default: err = 1'b1;
    endcase
    return err;
  endfunction

  function automatic logic [7:0] store_mask(input logic [2:0] f3,
                                            input logic [1:0] lo);
    logic [7:0] m;
    case (f3)
      F3_B:    m = WMASK_B << lo;
      F3_H:    m = WMASK_H << lo;
      F3_W:    m = WMASK_W;
      default: m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// ---------------------------------------------------------------------------
// lsu_load_align
// Combinational load formatter: picks the addressed byte/half out of the
// returned memory word and sign- or zero-extends it; words pass through.
// Ports:
//   mem_rdata  in  32  raw word from the responder
//   addr_lo    in  2   byte offset of the access within the word
//   funct3     in  3   width/sign code
//   rdata      out 32  formatted load data (0 for codes that are not loads)
// ---------------------------------------------------------------------------
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] mem_rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] rdata
);

  logic [31:0] lane;

  always_comb begin
    lane  = mem_rdata >> {addr_lo, 3'b000};
    rdata = '0;
    case (funct3)
      F3_B:    rdata = {{24{lane[7]}}, lane[7:0]};
      F3_H:    rdata = {{16{lane[15]}}, lane[15:0]};
      F3_W:    rdata = mem_rdata;
      F3_BU:   rdata = {24'd0, lane[7:0]};
      F3_HU:   rdata = {16'd0, lane[15:0]};
      default: rdata = '0;
    endcase
  end

endmodule

// File: rtl/lsu_req_ctrl.sv
// ---------------------------------------------------------------------------
// lsu_req_ctrl
// Initiator side of the data-memory interface. Accepts one load/store from
// execute, issues a level-held read request or a one-cycle write strobe,
// formats load data and hands a completion (with error flag) to write-back.
// At most one access is in flight.
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   in_valid/in_ready        execute handshake (ready only in IDLE)
//   in_load, in_store        access direction
//   in_funct3, in_addr       width/sign code, byte address
//   in_wdata                 right-justified store data
//   out_valid/out_ready      completion handshake to write-back
//   out_rdata, out_err       formatted load data, error flag
//   mem_req, mem_addr        read request (held until mem_ready), word addr
//   mem_ready, mem_rdata     read response
//   mem_wen, mem_waddr       one-cycle write strobe, word addr
//   mem_wdata, mem_wmask     lane-shifted store data, byte enables
// Parameters:
//   TIMEOUT  cycles to wait for mem_ready before aborting (0 = never)
//   CNT_W    timeout counter width, 2**CNT_W > TIMEOUT
// ---------------------------------------------------------------------------
module lsu_req_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_load,
  input  logic        in_store,
  input  logic [2:0]  in_funct3,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_rdata,
  output logic        out_err,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        mem_wen,
  output logic [31:0] mem_waddr,
  output logic [31:0] mem_wdata,
  output logic [7:0]  mem_wmask
);

  lsu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [1:0]       addr_lo_q, addr_lo_d;
  logic [2:0]       funct3_q, funct3_d;
  logic             out_err_q, out_err_d;
  logic [31:0]      out_rdata_q, out_rdata_d;
  logic [31:0]      mem_addr_q, mem_addr_d;
  logic [31:0]      mem_waddr_q, mem_waddr_d;
  logic [31:0]      mem_wdata_q, mem_wdata_d;
  logic [7:0]       mem_wmask_q, mem_wmask_d;
  logic [31:0]      load_data;

  lsu_load_align u_align (
    .mem_rdata (mem_rdata),
    .addr_lo   (addr_lo_q),
    .funct3    (funct3_q),
    .rdata     (load_data)
  );

  // Handshake strobes are pure state decodes so mem_req rises and falls
  // exactly once per read and mem_wen is a single cycle.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign mem_req   = (state_q == RD_WAIT);
  assign mem_wen   = (state_q == WR);
  assign out_rdata = out_rdata_q;
  assign out_err   = out_err_q;
  assign mem_addr  = mem_addr_q;
  assign mem_waddr = mem_waddr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wmask = mem_wmask_q;

  assign cnt_inc = cnt_q + CNT_W'(1);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_lo_d   = addr_lo_q;
    funct3_d    = funct3_q;
    out_err_d   = out_err_q;
    out_rdata_d = out_rdata_q;
    mem_addr_d  = mem_addr_q;
    mem_waddr_d = mem_waddr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wmask_d = mem_wmask_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          addr_lo_d   = in_addr[1:0];
          funct3_d    = in_funct3;
          out_rdata_d = '0;
          cnt_d       = '0;
          if (access_err(in_load, in_store, in_funct3, in_addr[1:0])) begin
            out_err_d = 1'b1;
            state_d   = DONE;
          end else if (in_load) begin
            mem_addr_d = {in_addr[31:2], 2'b00};
            state_d    = RD_WAIT;
          end else begin
            mem_waddr_d = {in_addr[31:2], 2'b00};
            mem_wdata_d = in_wdata << {in_addr[1:0], 3'b000};
            mem_wmask_d = store_mask(in_funct3, in_addr[1:0]);
            state_d     = WR;
          end
        end
      end

      RD_WAIT: begin
        // A response arriving on the same edge the timeout would fire wins.
        if (mem_ready) begin
          out_rdata_d = load_data;
          state_d     = DONE;
        end else if (TIMEOUT != 0) begin
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_W'(TIMEOUT)) begin
            out_err_d   = 1'b1;
            out_rdata_d = '0;
            state_d     = DONE;
          end
        end
      end

      WR: begin
        state_d = DONE;
      end

      DONE: begin
        if (out_ready) begin
          out_err_d   = 1'b0;
          out_rdata_d = '0;
          state_d     = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_lo_q   <= '0;
      funct3_q    <= '0;
      out_err_q   <= 1'b0;
      out_rdata_q <= '0;
      mem_addr_q  <= '0;
      mem_waddr_q <= '0;
      mem_wdata_q <= '0;
      mem_wmask_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_lo_q   <= addr_lo_d;
      funct3_q    <= funct3_d;
      out_err_q   <= out_err_d;
      out_rdata_q <= out_rdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_waddr_q <= mem_waddr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wmask_q <= mem_wmask_d;
    end
  end

endmodule

// File: tb/tb_lsu_req_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lsu_req_ctrl
// Transaction-level bench for lsu_req_ctrl (TIMEOUT=4). For each access the
// bench works out the outcome (error, data, mask) and a timeline of cycle
// offsets after acceptance; a single negedge process compares the DUT
// outputs against those expectations every cycle.
// ---------------------------------------------------------------------------
module tb_lsu_req_ctrl;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_load, in_store;
  logic [2:0]  in_funct3;
  logic [31:0] in_addr, in_wdata;
  logic        out_valid, out_ready, out_err;
  logic [31:0] out_rdata;
  logic        mem_req, mem_ready, mem_wen;
  logic [31:0] mem_addr, mem_rdata, mem_waddr, mem_wdata;
  logic [7:0]  mem_wmask;

  lsu_req_ctrl #(.TIMEOUT(TO), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_load(in_load),
    .in_store(in_store), .in_funct3(in_funct3), .in_addr(in_addr),
    .in_wdata(in_wdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata),
    .out_err(out_err),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata),
    .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Expectations for the current cycle, written just after each posedge.
  logic        chk_en = 1'b0;
  logic        exp_in_ready, exp_out_valid, exp_req, exp_wen, exp_zero;
  logic        exp_err;
  logic [31:0] exp_rdata, exp_mem_addr, exp_waddr, exp_wdata;
  logic [7:0]  exp_wmask;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  // ---------------- behavioural model ----------------
  function automatic int unsigned acc_size(logic [2:0] f3);
    return (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic model_err(logic ld, logic st, logic [2:0] f3,
                                     logic [31:0] a);
    logic legal;
    if (ld == st) return 1'b1;
    legal = ld ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})
               : (f3 inside {3'd0, 3'd1, 3'd2});
    if (!legal) return 1'b1;
    return (a % acc_size(f3)) != 0;
  endfunction

  function automatic logic [31:0] model_load(logic [2:0] f3, logic [1:0] off,
                                             logic [31:0] w);
    logic [31:0] v;
    v = w >> (8 * off);
    case (f3)
      3'd0:    return 32'($signed(v[7:0]));
      3'd1:    return 32'($signed(v[15:0]));
      3'd4:    return 32'(v[7:0]);
      3'd5:    return 32'(v[15:0]);
      default: return w;
    endcase
  endfunction

  function automatic logic [7:0] model_mask(logic [2:0] f3, logic [1:0] off);
    int unsigned sz;
    sz = acc_size(f3);
    return 8'(((1 << sz) - 1) << ((sz == 4) ? 0 : off));
  endfunction

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", 32'(in_ready), 32'(exp_in_ready));
      chk("out_valid", 32'(out_valid), 32'(exp_out_valid));
      chk("mem_req", 32'(mem_req), 32'(exp_req));
      chk("mem_wen", 32'(mem_wen), 32'(exp_wen));
      if (exp_req) chk("mem_addr", mem_addr, exp_mem_addr);
      if (exp_wen) begin
        chk("mem_waddr", mem_waddr, exp_waddr);
        chk("mem_wdata", mem_wdata, exp_wdata);
        chk("mem_wmask", 32'(mem_wmask), 32'(exp_wmask));
      end
      if (exp_out_valid) begin
        chk("out_rdata", out_rdata, exp_rdata);
        chk("out_err", 32'(out_err), 32'(exp_err));
      end else begin
        chk("out_err_idle", 32'(out_err), 32'd0);
      end
      if (exp_zero) begin
        chk("rst_out_rdata", out_rdata, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_waddr", mem_waddr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_mem_wmask", 32'(mem_wmask), 32'd0);
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    exp_in_ready  = 1'b1;
    exp_out_valid = 1'b0;
    exp_req       = 1'b0;
    exp_wen       = 1'b0;
  endtask

  // rdy_w: extra wait before the responder answers (-1 = never answers).
  // Cycle s (s>=1) is the cycle following the s-th edge after acceptance
  // minus one: s=1 is the cycle right after the accept edge.
  task automatic run_txn(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] rw, input int rdy_w,
                         input int hold);
    logic err, tmo, rdy_cyc;
    int   n, done_s;
    err = model_err(ld, st, f3, a);
    tmo = 1'b0;
    n   = 0;
    if (err) begin
      done_s = 1;
    end else if (ld) begin
      if (rdy_w < 0 || 2 + rdy_w > TO) begin
        n   = TO;
        tmo = 1'b1;
      end else begin
        n = 2 + rdy_w;
      end
      done_s = n + 1;
    end else begin
      done_s = 2;
    end
    exp_err      = err || tmo;
    exp_rdata    = (err || tmo || !ld) ? 32'd0 : model_load(f3, a[1:0], rw);
    exp_mem_addr = a & 32'hFFFF_FFFC;
    exp_waddr    = a & 32'hFFFF_FFFC;
    exp_wdata    = wd << (8 * a[1:0]);
    exp_wmask    = model_mask(f3, a[1:0]);

    set_idle();
    in_valid  = 1'b1;
    in_load   = ld;
    in_store  = st;
    in_funct3 = f3;
    in_addr   = a;
    in_wdata  = wd;
    mem_ready = 1'($urandom);
    mem_rdata = $urandom;
    out_ready = 1'($urandom);
    next_cycle();

    for (int s = 1; s <= 64; s++) begin
      in_valid  = 1'($urandom);
      in_load   = 1'($urandom);
      in_store  = 1'($urandom);
      in_funct3 = 3'($urandom);
      in_addr   = $urandom;
      in_wdata  = $urandom;
      exp_in_ready  = 1'b0;
      exp_req       = !err && ld && s <= n;
      exp_wen       = !err && st && s == 1;
      exp_out_valid = s >= done_s;
      rdy_cyc   = !err && ld && !tmo && s == 2 + rdy_w;
      mem_ready = rdy_cyc ? 1'b1 : (exp_req ? 1'b0 : 1'($urandom));
      mem_rdata = rdy_cyc ? rw : $urandom;
      out_ready = (s >= done_s + hold) ? 1'b1
                : (s < done_s) ? 1'($urandom) : 1'b0;
      next_cycle();
      if (s >= done_s + hold) break;
    end
    in_valid  = 1'b0;
    mem_ready = 1'($urandom);
    out_ready = 1'($urandom);
    set_idle();
  endtask

  task automatic idle_cycles(input int k);
    for (int i = 0; i < k; i++) begin
      set_idle();
      in_valid  = 1'b0;
      mem_ready = 1'($urandom);
      mem_rdata = $urandom;
      out_ready = 1'($urandom);
      next_cycle();
    end
  endtask

  // Reset while a read is outstanding; a late mem_ready must be ignored.
  task automatic reset_mid();
    set_idle();
    in_valid = 1'b1; in_load = 1'b1; in_store = 1'b0;
    in_funct3 = 3'd2; in_addr = 32'h1000_0010; in_wdata = '0;
    mem_ready = 1'b0; out_ready = 1'b0;
    exp_mem_addr = 32'h1000_0010;
    next_cycle();
    in_valid = 1'b0;
    exp_in_ready = 1'b0; exp_req = 1'b1;
    next_cycle();
    rst = 1'b0;
    next_cycle();
    rst = 1'b1;
    set_idle();
    exp_zero  = 1'b1;
    mem_ready = 1'b1;
    mem_rdata = 32'hCAFE_F00D;
    next_cycle();
    exp_zero  = 1'b0;
    mem_ready = 1'b0;
    next_cycle();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic        ld, st;
    logic [2:0]  f3;
    logic [31:0] a;
    int          r, w;

    rst = 1'b0; in_valid = 1'b0; in_load = 1'b0; in_store = 1'b0;
    in_funct3 = '0; in_addr = '0; in_wdata = '0; out_ready = 1'b0;
    mem_ready = 1'b0; mem_rdata = '0; exp_zero = 1'b0;
    exp_err = 1'b0; exp_rdata = '0; exp_mem_addr = '0; exp_waddr = '0;
    exp_wdata = '0; exp_wmask = '0;
    set_idle();

    // Pin the model against hand-worked values.
    chk("model_lb",  model_load(3'd0, 2'd3, 32'h80FF_1234), 32'hFFFF_FF80);
    chk("model_lbu", model_load(3'd4, 2'd3, 32'h80FF_1234), 32'h0000_0080);
    chk("model_lh",  model_load(3'd1, 2'd2, 32'h80FF_1234), 32'hFFFF_80FF);
    chk("model_lhu", model_load(3'd5, 2'd2, 32'h80FF_1234), 32'h0000_80FF);
    chk("model_sb_mask", 32'(model_mask(3'd0, 2'd1)), 32'h02);
    chk("model_sh_mask", 32'(model_mask(3'd1, 2'd2)), 32'h0C);
    chk("model_sw_mis", 32'(model_err(1'b0, 1'b1, 3'd2, 32'h8000_0006)), 32'd1);
    chk("model_lh_mis", 32'(model_err(1'b1, 1'b0, 3'd1, 32'h8000_0001)), 32'd1);

    repeat (3) @(posedge clk);
    #1;
    chk_en   = 1'b1;
    exp_zero = 1'b1;
    next_cycle();
    rst = 1'b1;
    next_cycle();
    exp_zero = 1'b0;

    // Directed accesses.
    run_txn(1, 0, 3'd2, 32'h8000_0008, 32'h0, 32'hDEAD_BEEF, 0, 0);
    run_txn(1, 0, 3'd0, 32'h8000_0003, 32'h0, 32'h80FF_1234, 0, 1);
    run_txn(1, 0, 3'd4, 32'h8000_0003, 32'h0, 32'h80FF_1234, 1, 0);
    run_txn(1, 0, 3'd1, 32'h8000_0002, 32'h0, 32'h80FF_1234, 2, 0);
    run_txn(1, 0, 3'd5, 32'h8000_0002, 32'h0, 32'h80FF_1234, 0, 2);
    run_txn(0, 1, 3'd0, 32'h8000_0001, 32'h0000_00AB, 32'h0, 0, 0);
    run_txn(0, 1, 3'd2, 32'h8000_0006, 32'h1234_5678, 32'h0, 0, 0);
    run_txn(1, 0, 3'd3, 32'h8000_0000, 32'h0, 32'h0, 0, 0);
    run_txn(1, 0, 3'd1, 32'h8000_0001, 32'h0, 32'h0, 0, 0);
    run_txn(1, 0, 3'd2, 32'h8000_0010, 32'h0, 32'h0, -1, 0);
    run_txn(1, 0, 3'd2, 32'h8000_0014, 32'h0, 32'h1357_9BDF, 0, 5);
    run_txn(1, 1, 3'd2, 32'h8000_0000, 32'h0, 32'h0, 0, 0);
    run_txn(0, 0, 3'd2, 32'h8000_0000, 32'h0, 32'h0, 0, 1);
    reset_mid();

    // Randomized accesses.
    for (int t = 0; t < 300; t++) begin
      r = int'($urandom % 8);
      ld = (r <= 2) || (r == 6);
      st = (r >= 3 && r <= 5) || (r == 6);
      if (st && !ld) begin
        r  = int'($urandom % 5);
        f3 = (r <= 2) ? 3'(r) : (r == 3) ? 3'd3 : 3'd7;
      end else begin
        f3 = 3'($urandom);
      end
      a = $urandom;
      if ($urandom % 2 == 0) a[1:0] = 2'b00;
      w = int'($urandom % 4);
      if (w == 3) w = -1;
      run_txn(ld, st, f3, a, $urandom, $urandom, w, int'($urandom % 4));
      idle_cycles(int'($urandom % 3));
      if (t == 150) reset_mid();
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, %0d tests run", tests);
    $fatal(1, "watchdog expired");
  end

endmodule
